ysyx_23060124_stage_fifo: RTL and testbench

//  Parametrised valid/ready stage buffer placed between pipeline stages (IFU->IDU, IDU->EXU, EXU->WBU).

---
 rtl/ysyx_23060124_stage_fifo.sv | 126 ++++++++++++
 tb/tb_ysyx_23060124_stage_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_stage_fifo.sv
// ysyx_23060124_stage_fifo
//   Elastic valid/ready buffer between pipeline stages. Holds up to DEPTH
//   entries in a circular store. When BYPASS is set, an empty buffer passes the
//   input straight to the output in the same cycle. A synchronous flush drops
//   every entry so that a branch, jump, ecall or mret can redirect the pipeline.
//   o_pre_ready is computed only from registered state and i_flush, so there is
//   no combinational path from i_post_ready to it.
//
// Ports
//   clk           clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_flush       synchronous flush, discards all entries
//   i_pre_valid   producer has data on i_data
//   o_pre_ready   buffer can accept data this cycle
//   i_data        producer payload
//   o_post_valid  o_data is valid for the consumer
//   i_post_ready  consumer accepts o_data this cycle
//   o_data        head entry, or the bypassed input
//   o_count       number of stored entries
//   o_full        o_count == DEPTH
//   o_empty       o_count == 0
module ysyx_23060124_stage_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic empty, full;
  logic push, pop;
  logic push_st, pop_st;
  logic thru;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign o_pre_ready = !full && !i_flush;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign o_post_valid = (!empty || i_pre_valid) && !i_flush;
      assign o_data       = empty ? i_data : mem_q[rd_ptr_q];
      // Empty buffer with both sides transferring: the word never lands in storage.
      assign thru         = empty && push && pop;
    end else begin : g_reg
      assign o_post_valid = !empty && !i_flush;
      assign o_data       = mem_q[rd_ptr_q];
      assign thru         = 1'b0;
    end
  endgenerate

  assign push    = i_pre_valid && o_pre_ready;
  assign pop     = o_post_valid && i_post_ready;
  assign push_st = push && !thru;
  assign pop_st  = pop && !empty;

  assign o_count = count_q;
  assign o_full  = full;
  assign o_empty = empty;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_st) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_st)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_st, pop_st})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flush leaves storage untouched; only the pointers forget it.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_st) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_stage_fifo.sv
module tb_ysyx_23060124_stage_fifo;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_pre_valid = 1'b0;
  logic        i_post_ready = 1'b0;
  logic [31:0] i_data = 32'h0;

  // a: DEPTH=2 BYPASS=0, b: DEPTH=3 BYPASS=0, c: DEPTH=2 BYPASS=1
  logic        a_rdy, a_vld, a_full, a_empty;
  logic [31:0] a_data;
  logic [1:0]  a_cnt;
  logic        b_rdy, b_vld, b_full, b_empty;
  logic [31:0] b_data;
  logic [1:0]  b_cnt;
  logic        c_rdy, c_vld, c_full, c_empty;
  logic [31:0] c_data;
  logic [1:0]  c_cnt;

  always #5 clk = ~clk;

  ysyx_23060124_stage_fifo #(.WIDTH(32), .DEPTH(2), .BYPASS(0)) dut_a (
    .clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_pre_valid(i_pre_valid), .o_pre_ready(a_rdy), .i_data(i_data),
    .o_post_valid(a_vld), .i_post_ready(i_post_ready), .o_data(a_data),
    .o_count(a_cnt), .o_full(a_full), .o_empty(a_empty));

  ysyx_23060124_stage_fifo #(.WIDTH(32), .DEPTH(3), .BYPASS(0)) dut_b (
    .clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_pre_valid(i_pre_valid), .o_pre_ready(b_rdy), .i_data(i_data),
    .o_post_valid(b_vld), .i_post_ready(i_post_ready), .o_data(b_data),
    .o_count(b_cnt), .o_full(b_full), .o_empty(b_empty));

  ysyx_23060124_stage_fifo #(.WIDTH(32), .DEPTH(2), .BYPASS(1)) dut_c (
    .clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_pre_valid(i_pre_valid), .o_pre_ready(c_rdy), .i_data(i_data),
    .o_post_valid(c_vld), .i_post_ready(i_post_ready), .o_data(c_data),
    .o_count(c_cnt), .o_full(c_full), .o_empty(c_empty));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        pv, pr, fl;
    logic [31:0] d;
    logic        e_rdy, e_vld;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic pv, input logic pr, input logic fl,
                              input logic [31:0] d, input logic e_rdy, input logic e_vld,
                              input logic [31:0] e_data, input logic [1:0] e_cnt);
    vec_t v;
    v.pv = pv; v.pr = pr; v.fl = fl; v.d = d;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic pv, input logic pr, input logic fl, input logic [31:0] d);
    i_pre_valid  = pv;
    i_post_ready = pr;
    i_flush      = fl;
    i_data       = d;
  endtask

  // Leaves the bench at posedge+1 with reset released mid low phase.
  task automatic do_reset();
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_a_rdy",   a_rdy, 1);
    chk("rst_a_vld",   a_vld, 0);
    chk("rst_a_data",  a_data, 0);
    chk("rst_a_cnt",   a_cnt, 0);
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_full",  a_full, 0);
    chk("rst_c_vld",   c_vld, 0);
    chk("rst_c_data",  c_data, 0);
    @(negedge clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DEPTH=2 BYPASS=0 directed table: fill, full, pop-on-full, wrap, flush
    vt[0]  = mk(1, 0, 0, 32'h11, 1, 0, 32'h00, 0);
    vt[1]  = mk(1, 0, 0, 32'h22, 1, 1, 32'h11, 1);
    vt[2]  = mk(1, 0, 0, 32'h33, 0, 1, 32'h11, 2);
    vt[3]  = mk(1, 1, 0, 32'h33, 0, 1, 32'h11, 2);
    vt[4]  = mk(1, 0, 0, 32'h33, 1, 1, 32'h22, 1);
    vt[5]  = mk(0, 1, 0, 32'h00, 0, 1, 32'h22, 2);
    vt[6]  = mk(0, 1, 0, 32'h00, 1, 1, 32'h33, 1);
    vt[7]  = mk(1, 1, 0, 32'h44, 1, 0, 32'h22, 0);
    vt[8]  = mk(1, 1, 0, 32'h55, 1, 1, 32'h44, 1);
    vt[9]  = mk(1, 0, 1, 32'h66, 0, 0, 32'h55, 1);
    vt[10] = mk(1, 0, 0, 32'h77, 1, 0, 32'h55, 0);
    vt[11] = mk(1, 0, 0, 32'h88, 1, 1, 32'h77, 1);
    vt[12] = mk(1, 1, 1, 32'h99, 0, 0, 32'h77, 2);
    vt[13] = mk(0, 0, 0, 32'h00, 1, 0, 32'h77, 0);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].pv, vt[i].pr, vt[i].fl, vt[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i),   a_rdy,   vt[i].e_rdy);
      chk($sformatf("v%0d_vld", i),   a_vld,   vt[i].e_vld);
      if (vt[i].e_vld) chk($sformatf("v%0d_data", i), a_data, vt[i].e_data);
      chk($sformatf("v%0d_cnt", i),   a_cnt,   vt[i].e_cnt);
      chk($sformatf("v%0d_full", i),  a_full,  vt[i].e_cnt == 2'd2);
      chk($sformatf("v%0d_empty", i), a_empty, vt[i].e_cnt == 2'd0);
      @(posedge clk);
      #1;
    end

    // DEPTH=3 streaming: one word in flight, pointers wrap without loss
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(k));
      @(negedge clk);
      chk($sformatf("s%0d_vld", k), b_vld, k != 0);
      chk($sformatf("s%0d_cnt", k), b_cnt, (k == 0) ? 0 : 1);
      if (k != 0) chk($sformatf("s%0d_data", k), b_data, 32'(k - 1));
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("s_last_data", b_data, 32'd19);
    chk("s_last_vld",  b_vld, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s_drained", b_empty, 1);
    @(posedge clk);
    #1;

    // BYPASS=1 on empty
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'hABCD);
    @(negedge clk);
    chk("byp_vld",  c_vld, 1);
    chk("byp_data", c_data, 32'hABCD);
    chk("byp_rdy",  c_rdy, 1);
    @(posedge clk);
    #1;
    chk("byp_cnt_after", c_cnt, 0);
    drive(1'b1, 1'b0, 1'b0, 32'hABCD);
    @(negedge clk);
    chk("byp_hold_vld",  c_vld, 1);
    chk("byp_hold_data", c_data, 32'hABCD);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("byp_stored_cnt",  c_cnt, 1);
    chk("byp_stored_data", c_data, 32'hABCD);
    chk("byp_stored_vld",  c_vld, 1);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b1, 32'h1234);
    @(negedge clk);
    chk("byp_flush_vld", c_vld, 0);
    chk("byp_flush_rdy", c_rdy, 0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("byp_flush_cnt",   c_cnt, 0);
    chk("byp_flush_empty", c_empty, 1);
    @(posedge clk);
    #1;

    // async reset mid-stream
    drive(1'b1, 1'b0, 1'b0, 32'hA1);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'hA2);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("ar_pre_cnt", a_cnt, 2);
    i_rst_n = 1'b0;
    #1;
    chk("ar_rdy",   a_rdy, 1);
    chk("ar_vld",   a_vld, 0);
    chk("ar_data",  a_data, 0);
    chk("ar_cnt",   a_cnt, 0);
    chk("ar_empty", a_empty, 1);
    chk("ar_full",  a_full, 0);
    #4;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h5A);
    @(negedge clk);
    chk("ar_re_vld0", a_vld, 0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("ar_re_vld1", a_vld, 1);
    chk("ar_re_data", a_data, 32'h5A);
    chk("ar_re_cnt",  a_cnt, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ar_re_empty", a_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
